// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave configuration controller:
// FSM state encoding and default parameter values.
package spi_slave_pkg;

    localparam int NUM_REGS_DEF    = 2;
    localparam int REG_W_DEF       = 8;
    localparam int ACK_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WRITE,
        WAIT_ACK,
        DONE,
        ERR
    } cfg_state_e;

endpackage

// File: rtl/spi_cfg_timeout.sv
// Ack-timeout counter: cleared on each word write, counts cycles spent
// waiting for an ack, and flags expiry on the ACK_TIMEOUT-th waiting cycle.
import spi_slave_pkg::*;

module spi_cfg_timeout #(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Expiry is qualified by enable so a same-cycle ack always wins.
    assign expired = enable && (count_reg == LAST_CNT);

endmodule

// File: rtl/spi_slave_cfg_ctrl.sv
// Writes NUM_REGS configuration words to an SPI slave, one ack per word.
// Optional macro SPI_CFG_AUTO_START_EN starts a sequence right after reset.
import spi_slave_pkg::*;

module spi_slave_cfg_ctrl #(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int REG_W       = REG_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_REGS*REG_W-1:0] cfg_vals,
    input  logic                      slave_busy,
    input  logic                      reg_ack,
    output logic [REG_W-1:0]          reg_din,
    output logic                      reg_din_val,
    output logic                      cfg_busy,
    output logic                      done,
    output logic                      err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    cfg_state_e       state_reg, state_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic             capture;
    logic             start_eff;
    logic             timeout_expired;

    logic [REG_W-1:0] cfg_words  [NUM_REGS];
    logic [REG_W-1:0] shadow_reg [NUM_REGS];

    logic [REG_W-1:0] reg_din_reg;
    logic             reg_din_val_reg;
    logic             cfg_busy_reg;
    logic             done_reg;
    logic             err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_words
            assign cfg_words[gi] = cfg_vals[gi*REG_W +: REG_W];
        end
    endgenerate

`ifdef SPI_CFG_AUTO_START_EN
    logic auto_start_reg;

    // High for exactly the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_start_reg <= 1'b1;
        end else begin
            auto_start_reg <= 1'b0;
        end
    end

    assign start_eff = start | auto_start_reg;
`else
    assign start_eff = start;
`endif

    spi_cfg_timeout #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg == WRITE),
        .enable  ((state_reg == WAIT_ACK) && !reg_ack),
        .expired (timeout_expired)
    );

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_eff) begin
                    capture    = 1'b1;
                    index_next = '0;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!slave_busy) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (reg_ack) begin
                    if (index_reg < LAST_IDX) begin
                        index_next = index_reg + IDX_W'(1);
                        state_next = WRITE;
                    end else begin
                        state_next = DONE;
                    end
                end else if (timeout_expired) begin
                    state_next = ERR;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            reg_din_reg     <= '0;
            reg_din_val_reg <= 1'b0;
            cfg_busy_reg    <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            reg_din_val_reg <= (state_next == WRITE);
            done_reg        <= (state_next == DONE);
            cfg_busy_reg    <= (state_next == WAIT_IDLE) || (state_next == WRITE) ||
                               (state_next == WAIT_ACK);
            if (capture) begin
                shadow_reg <= cfg_words;
            end
            if (state_next == WRITE) begin
                reg_din_reg <= shadow_reg[index_next];
            end
            if (capture) begin
                err_reg <= 1'b0;
            end else if (state_next == ERR) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign reg_din     = reg_din_reg;
    assign reg_din_val = reg_din_val_reg;
    assign cfg_busy    = cfg_busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_spi_slave_cfg_ctrl.sv
// Directed self-checking bench for spi_slave_cfg_ctrl (NUM_REGS=2, REG_W=8,
// ACK_TIMEOUT=4); honours SPI_CFG_AUTO_START_EN when defined.
module tb_spi_slave_cfg_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_vals;
    logic        slave_busy;
    logic        reg_ack;
    logic [7:0]  reg_din;
    logic        reg_din_val;
    logic        cfg_busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    spi_slave_cfg_ctrl #(
        .NUM_REGS    (2),
        .REG_W       (8),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_vals    (cfg_vals),
        .slave_busy  (slave_busy),
        .reg_ack     (reg_ack),
        .reg_din     (reg_din),
        .reg_din_val (reg_din_val),
        .cfg_busy    (cfg_busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_din"},  32'(reg_din), 32'h0);
        check({tag, "_val"},  32'(reg_din_val), 32'h0);
        check({tag, "_busy"}, 32'(cfg_busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_err"},  32'(err), 32'h0);
    endtask

    // Caller has presented start (or auto-start) in the current cycle (cycle 0).
    // Slave is busy for cycles 1..busy_hold; each word is acked the cycle after
    // its valid. poke re-asserts start with new cfg_vals, and acks during WRITE.
    task automatic run_seq(input logic [15:0] vals, input int busy_hold, input bit poke);
        logic [7:0] word;
        step();
        start   = 1'b0;
        reg_ack = 1'b0;
        check("busy_at_start", 32'(cfg_busy), 32'h1);
        check("err_cleared", 32'(err), 32'h0);
        for (int c = 1; c <= busy_hold; c++) begin
            slave_busy = 1'b1;
            check("busy_hold_noval", 32'(reg_din_val), 32'h0);
            step();
        end
        slave_busy = 1'b0;
        check("wait_idle_noval", 32'(reg_din_val), 32'h0);
        step();
        for (int w = 0; w < 2; w++) begin
            word = vals[w*8 +: 8];
            $display("word %0d: reg_din=%02h expect %02h val=%0b", w, reg_din, word, reg_din_val);
            check("write_val", 32'(reg_din_val), 32'h1);
            check("write_din", 32'(reg_din), 32'(word));
            if (poke && w == 1) reg_ack = 1'b1;
            step();
            check("ack_val_drop", 32'(reg_din_val), 32'h0);
            check("ack_din_hold", 32'(reg_din), 32'(word));
            check("ack_busy", 32'(cfg_busy), 32'h1);
            check("ack_nodone", 32'(done), 32'h0);
            reg_ack = 1'b1;
            if (poke && w == 0) begin
                start    = 1'b1;
                cfg_vals = ~vals;
            end
            if (poke && w == 1) start = 1'b0;
            step();
            reg_ack = 1'b0;
        end
        $display("sequence %04h: done=%0b busy=%0b err=%0b", vals, done, cfg_busy, err);
        check("done_pulse", 32'(done), 32'h1);
        check("done_busy_clr", 32'(cfg_busy), 32'h0);
        check("done_err", 32'(err), 32'h0);
        step();
        check("done_one_cycle", 32'(done), 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_vals   = 16'h3C96;
        slave_busy = 1'b0;
        reg_ack    = 1'b0;
        step();
        step();
        check_all_zero("reset");

        // Release reset: auto-start build runs a sequence, default build idles.
        rst = 1'b0;
`ifdef SPI_CFG_AUTO_START_EN
        run_seq(16'h3C96, 0, 1'b0);
`else
        for (int i = 0; i < 5; i++) begin
            step();
            check("no_auto_val", 32'(reg_din_val), 32'h0);
            check("no_auto_busy", 32'(cfg_busy), 32'h0);
        end
`endif
        step();

        // Basic sequence, minimum latency.
        cfg_vals = 16'hA55A;
        start    = 1'b1;
        run_seq(16'hA55A, 0, 1'b0);

        // Slave busy for 10 cycles after start.
        cfg_vals = 16'h1234;
        start    = 1'b1;
        run_seq(16'h1234, 10, 1'b0);

        // Start pulses and changed cfg_vals mid-sequence are ignored.
        cfg_vals = 16'hC381;
        start    = 1'b1;
        run_seq(16'hC381, 0, 1'b1);
        step();

        // Ack timeout: four WAIT_ACK cycles without ack, then ERR.
        cfg_vals = 16'h55AA;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        check("to_write_val", 32'(reg_din_val), 32'h1);
        check("to_write_din", 32'(reg_din), 32'hAA);
        step();
        for (int k = 3; k <= 6; k++) begin
            check("to_wait_err", 32'(err), 32'h0);
            check("to_wait_busy", 32'(cfg_busy), 32'h1);
            step();
        end
        $display("timeout: err=%0b busy=%0b done=%0b", err, cfg_busy, done);
        check("to_err_set", 32'(err), 32'h1);
        check("to_busy_clr", 32'(cfg_busy), 32'h0);
        check("to_nodone", 32'(done), 32'h0);
        step();
        check("to_err_sticky", 32'(err), 32'h1);
        check("to_nodone2", 32'(done), 32'h0);
        step();
        check("to_err_sticky2", 32'(err), 32'h1);
        cfg_vals = 16'h7E24;
        start    = 1'b1;
        run_seq(16'h7E24, 0, 1'b0);

        // Reset during WAIT_ACK of word 1.
        cfg_vals = 16'hBEEF;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        check("rm_din0", 32'(reg_din), 32'hEF);
        step();
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        check("rm_din1", 32'(reg_din), 32'hBE);
        step();
        check("rm_busy", 32'(cfg_busy), 32'h1);
        rst = 1'b1;
        step();
        $display("mid reset: din=%02h val=%0b busy=%0b", reg_din, reg_din_val, cfg_busy);
        check_all_zero("mid_reset");
        rst     = 1'b0;
        reg_ack = 1'b1;
`ifdef SPI_CFG_AUTO_START_EN
        run_seq(16'hBEEF, 0, 1'b0);
`else
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_val", 32'(reg_din_val), 32'h0);
            check("post_rst_busy", 32'(cfg_busy), 32'h0);
            check("post_rst_done", 32'(done), 32'h0);
        end
        reg_ack = 1'b0;
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_cfg_ctrl.md
SPI_SLAVE_CFG_CTRL -- requirements
Module: spi_slave_cfg_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 2: number of configuration words written per sequence.
REQ-002 SHALL have parameter REG_W, default 8: width of one configuration word.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: maximum WAIT_ACK cycles before error.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: configuration sequence request.
REQ-007 SHALL have port cfg_vals, input, NUM_REGS*REG_W bits: configuration words; word 0 in the LSBs.
REQ-008 SHALL have port slave_busy, input, 1 bit: SPI slave transaction in progress.
REQ-009 SHALL have port reg_ack, input, 1 bit: the SPI slave accepted the word.
REQ-010 SHALL have port reg_din, output, REG_W bits: configuration word to the SPI slave.
REQ-011 SHALL have port reg_din_val, output, 1 bit: reg_din valid.
REQ-012 SHALL have port cfg_busy, output, 1 bit: sequence in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 SHALL have port err, output, 1 bit: sticky ack-timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_IDLE, WRITE, WAIT_ACK, DONE and ERR; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL capture cfg_vals into a shadow register, clear err and the word index, set cfg_busy, and enter WAIT_IDLE.
REQ-017 start SHALL be ignored in every state other than IDLE; the shadow register SHALL NOT change mid-sequence.
REQ-018 WAIT_IDLE SHALL remain while slave_busy=1 and SHALL enter WRITE on the first cycle with slave_busy=0; slave_busy is not re-checked between words.
REQ-019 WRITE SHALL last exactly one cycle with reg_din_val=1 and reg_din = shadow word[index], then enter WAIT_ACK; reg_din SHALL hold that value until the next WRITE.
REQ-020 reg_ack SHALL be sampled only in WAIT_ACK; reg_ack during WRITE or any other state SHALL be ignored.
REQ-021 In WAIT_ACK, reg_ack=1 SHALL go to WRITE with index+1 if index<NUM_REGS-1, else to DONE.
REQ-022 The timeout counter SHALL clear in WRITE and increment each WAIT_ACK cycle without ack; reaching ACK_TIMEOUT SHALL enter ERR; ack and timeout in the same cycle SHALL count as ack.
REQ-023 DONE SHALL pulse done=1 for one cycle, clear cfg_busy, and return to IDLE.
REQ-024 ERR SHALL set err=1, clear cfg_busy, and return to IDLE next cycle; err SHALL hold until the next accepted start or rst.
REQ-025 Minimum latency with slave_busy=0 and immediate ack: start at cycle 0, first reg_din_val at cycle 2, done at cycle 2*NUM_REGS+2.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, with index, timeout counter, shadow register and reg_din at 0, and reg_din_val, cfg_busy, done and err at 0, in any state including mid-sequence.
REQ-027 rst SHALL take priority over start and reg_ack in the same cycle.

Configuration
REQ-028 Macro SPI_CFG_AUTO_START_EN: when defined, the first cycle after rst deasserts SHALL behave as start=1 (cfg_vals captured); when undefined, sequences begin only on an explicit start.

Structure
REQ-029 Package spi_slave_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-030 The ack-timeout counter SHALL be the sub-module spi_cfg_timeout (inputs clear and enable; output expired).

Verification
REQ-031 Bench: NUM_REGS=2, cfg_vals=16'hA55A, start at cycle 0, slave_busy=0, ack one cycle after each val -> reg_din 8'h5A then 8'hA5, done at cycle 6, err=0.
REQ-032 Bench: slave_busy=1 for 10 cycles after start -> no reg_din_val until slave_busy falls, then normal sequence.
REQ-033 Bench: no reg_ack with ACK_TIMEOUT=4 -> err=1 after 4 WAIT_ACK cycles, done never pulses; a new start clears err.
REQ-034 Bench: rst asserted mid-WAIT_ACK of word 1 -> all outputs 0 next cycle; reg_ack after reset is ignored.
REQ-035 Bench: start pulses during the sequence, with cfg_vals changed -> ignored; written words equal the values captured at the first start.
REQ-036 Bench: with SPI_CFG_AUTO_START_EN defined -> a sequence runs after reset without start; undefined -> no reg_din_val until start.
